// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: widths, FSM encoding, GF(2^8) helpers
// and the forward/inverse circulant coefficients.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte j is the coefficient applied to the byte j positions to the right of
  // the output row (circulant row 0 read left to right).
  localparam logic [COL_W-1:0] FWD_COEF = 32'h01_01_03_02;
  localparam logic [COL_W-1:0] INV_COEF = 32'h09_0D_0B_0E;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] coef);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = 8'h00;
    pow = a;
    for (int i = 0; i < 8; i++) begin
      if (coef[i]) acc = acc ^ pow;
      pow = xtime(pow);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_mix_col.sv
// Combinational (Inv)MixColumns of one 32-bit column; row r sits in bits [8r+7:8r].
module gf_mix_col
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             inverse_i,
  output logic [COL_W-1:0] col_o
);

  logic [COL_W-1:0] coef;

  always_comb begin
    coef  = inverse_i ? INV_COEF : FWD_COEF;
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        col_o[8*r +: 8] = col_o[8*r +: 8] ^ gf_mul(col_i[8*j +: 8], coef[8*((j - r) & 3) +: 8]);
      end
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns/InvMixColumns: one 128-bit state per transaction,
// COLS_PER_CYCLE columns transformed per RUN cycle.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  input  logic               inverse,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy,
  output state_e             dbg_state_o
);

  localparam int         STEPS    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] CNT_LAST = 2'(STEPS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid,
  // once raised, is held with its data until that edge. in_ready is high only
  // in IDLE and out_valid only in DONE, so input and output never overlap.

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] src_q, src_d;
  logic [STATE_W-1:0] res_q, res_d;
  logic               inv_q, inv_d;

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] mix_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] mix_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = 2'(int'(cnt_q) * COLS_PER_CYCLE + g);
    assign mix_in[g]  = src_q[COL_W*col_idx[g] +: COL_W];

    gf_mix_col u_mix (
      .col_i     (mix_in[g]),
      .inverse_i (inv_q),
      .col_o     (mix_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    inv_d   = inv_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_data;
          inv_d   = inverse;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          res_d[COL_W*col_idx[g] +: COL_W] = mix_out[g];
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      src_q   <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_data    = res_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: one instance each for 1, 2 and 4 columns per cycle,
// checked against a polynomial-arithmetic GF(2^8) reference model.
module tb_mix_columns_seq;
  import aes_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         inverse   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];
  state_e       dbg_state [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .in_data     (in_data[g]),
      .inverse     (inverse[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .out_data    (out_data[g]),
      .busy        (busy[g]),
      .dbg_state_o (dbg_state[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) m = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ ref_mul(m[(j - row + 4) % 4], s[32*c + 8*j +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offers a state, waits for acceptance, then scrambles the inputs so that
  // any late sampling of in_data/inverse corrupts the result.
  task automatic send(input int i, input logic [127:0] d, input logic inv);
    int guard;
    guard       = 0;
    in_data[i]  = d;
    inverse[i]  = inv;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_wait", 128'(guard < 50), 128'(1));
    tick();
    in_valid[i] = 1'b0;
    in_data[i]  = rand128();
    tick_toggle(i, inv);
  endtask

  task automatic tick_toggle(input int i, input logic inv);
    inverse[i] = ~inv;
  endtask

  task automatic wait_valid(input int i);
    int   lat;
    logic rdy_seen;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid[i] && lat < 20) begin
      if (in_ready[i]) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    check($sformatf("latency_c%0d", 1 << i), 128'(lat), 128'(4 >> i));
    check($sformatf("ready_low_run_c%0d", 1 << i), 128'(rdy_seen), 128'(0));
    check($sformatf("ready_low_done_c%0d", 1 << i), 128'(in_ready[i]), 128'(0));
  endtask

  task automatic take(input int i, output logic [127:0] got);
    got          = out_data[i];
    out_ready[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
    check($sformatf("idle_after_hs_c%0d", 1 << i), 128'(busy[i]), 128'(0));
  endtask

  task automatic xfer(input int i, input logic [127:0] d, input logic inv, input string tag);
    logic [127:0] got;
    exp_q.push_back(ref_mix(d, inv));
    send(i, d, inv);
    wait_valid(i);
    take(i, got);
    check($sformatf("%s_c%0d", tag, 1 << i), got, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] known_in, known_fwd, s, a, b, hold, got;
  logic         inv_r;
  logic         seen;

  initial begin
    known_in  = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
    known_fwd = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      inverse[i]   = 1'b0;
      out_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 128'(in_ready[i]), 128'(1));
      check("rst_out_valid", 128'(out_valid[i]), 128'(0));
      check("rst_out_data", out_data[i], 128'(0));
      check("rst_busy", 128'(busy[i]), 128'(0));
    end

    // Known vectors in both directions, every column width.
    for (int i = 0; i < 3; i++) begin
      send(i, known_in, 1'b0);
      wait_valid(i);
      take(i, got);
      check($sformatf("known_fwd_c%0d", 1 << i), got, known_fwd);
      send(i, known_fwd, 1'b1);
      wait_valid(i);
      take(i, got);
      check($sformatf("known_inv_c%0d", 1 << i), got, known_in);
    end

    // Random states, random mode; then forward/inverse round trips.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 6; n++) begin
        inv_r = 1'($urandom_range(0, 1));
        xfer(i, rand128(), inv_r, "rand");
      end
      s = rand128();
      send(i, s, 1'b0);
      wait_valid(i);
      take(i, a);
      send(i, a, 1'b1);
      wait_valid(i);
      take(i, b);
      check($sformatf("round_trip_c%0d", 1 << i), b, s);
    end

    // Backpressure with a pending offer while the result is held.
    s = rand128();
    send(0, s, 1'b0);
    wait_valid(0);
    hold        = out_data[0];
    in_valid[0] = 1'b1;
    in_data[0]  = rand128();
    for (int k = 0; k < 6; k++) begin
      tick();
      check("bp_out_valid", 128'(out_valid[0]), 128'(1));
      check("bp_out_data", out_data[0], hold);
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
    end
    check("bp_result", hold, ref_mix(s, 1'b0));
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("bp_idle_state", 128'(dbg_state[0]), 128'(IDLE));
    check("bp_idle_ready", 128'(in_ready[0]), 128'(1));
    in_valid[0] = 1'b0;
    tick();

    // Reset while the counter is at 1: nothing may come out for that state.
    send(0, rand128(), 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", 128'(out_valid[0]), 128'(0));
    check("mid_rst_out_data", out_data[0], 128'(0));
    check("mid_rst_busy", 128'(busy[0]), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready[0]), 128'(1));
    seen = 1'b0;
    out_ready[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid[0]) seen = 1'b1;
      tick();
    end
    out_ready[0] = 1'b0;
    check("mid_rst_no_output", 128'(seen), 128'(0));
    xfer(0, rand128(), 1'b1, "post_rst");

    // Identity column in both modes.
    for (int i = 0; i < 3; i++) begin
      send(i, {4{32'h01010101}}, i[0]);
      wait_valid(i);
      take(i, got);
      check($sformatf("identity_c%0d", 1 << i), got, {4{32'h01010101}});
    end

    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
